// File: rtl/ysyx_25040111_lsu_axi_if.sv
// AXI4 master and read-only local port bundle for the ysyx_25040111 LSU.
// The master modport is the LSU side; the slave modport is the memory side.
interface ysyx_25040111_lsu_axi_if #(
   parameter int DATA_W = 32
);
   logic                  io_master_awvalid;
   logic                  io_master_awready;
   logic [31:0]           io_master_awaddr;
   logic [3:0]            io_master_awid;
   logic [7:0]            io_master_awlen;
   logic [2:0]            io_master_awsize;
   logic [1:0]            io_master_awburst;

   logic                  io_master_wvalid;
   logic                  io_master_wready;
   logic [DATA_W-1:0]     io_master_wdata;
   logic [DATA_W/8-1:0]   io_master_wstrb;
   logic                  io_master_wlast;

   logic                  io_master_bvalid;
   logic                  io_master_bready;
   logic [1:0]            io_master_bresp;
   logic [3:0]            io_master_bid;

   logic                  io_master_arvalid;
   logic                  io_master_arready;
   logic [31:0]           io_master_araddr;
   logic [3:0]            io_master_arid;
   logic [7:0]            io_master_arlen;
   logic [2:0]            io_master_arsize;
   logic [1:0]            io_master_arburst;

   logic                  io_master_rvalid;
   logic                  io_master_rready;
   logic [1:0]            io_master_rresp;
   logic [DATA_W-1:0]     io_master_rdata;
   logic                  io_master_rlast;
   logic [3:0]            io_master_rid;

   logic                  loc_arvalid;
   logic                  loc_arready;
   logic [31:0]           loc_araddr;
   logic                  loc_rvalid;
   logic                  loc_rready;
   logic [DATA_W-1:0]     loc_rdata;
   logic [1:0]            loc_rresp;

   modport master (
      output io_master_awvalid, io_master_awaddr, io_master_awid,
             io_master_awlen, io_master_awsize, io_master_awburst,
      input  io_master_awready,
      output io_master_wvalid, io_master_wdata, io_master_wstrb,
             io_master_wlast,
      input  io_master_wready,
      output io_master_bready,
      input  io_master_bvalid, io_master_bresp, io_master_bid,
      output io_master_arvalid, io_master_araddr, io_master_arid,
             io_master_arlen, io_master_arsize, io_master_arburst,
      input  io_master_arready,
      output io_master_rready,
      input  io_master_rvalid, io_master_rresp, io_master_rdata,
             io_master_rlast, io_master_rid,
      output loc_arvalid, loc_araddr, loc_rready,
      input  loc_arready, loc_rvalid, loc_rdata, loc_rresp
   );

   modport slave (
      input  io_master_awvalid, io_master_awaddr, io_master_awid,
             io_master_awlen, io_master_awsize, io_master_awburst,
      output io_master_awready,
      input  io_master_wvalid, io_master_wdata, io_master_wstrb,
             io_master_wlast,
      output io_master_wready,
      input  io_master_bready,
      output io_master_bvalid, io_master_bresp, io_master_bid,
      input  io_master_arvalid, io_master_araddr, io_master_arid,
             io_master_arlen, io_master_arsize, io_master_arburst,
      output io_master_arready,
      input  io_master_rready,
      output io_master_rvalid, io_master_rresp, io_master_rdata,
             io_master_rlast, io_master_rid,
      input  loc_arvalid, loc_araddr, loc_rready,
      output loc_arready, loc_rvalid, loc_rdata, loc_rresp
   );
endinterface

// File: rtl/ysyx_25040111_lsu_axi.sv
// Single-outstanding load/store unit on AXI4 plus a read-only local port.
// Define LSU_PMC_EN to build the load/store/error/wait performance counters.
module ysyx_25040111_lsu_axi #(
   parameter int          DATA_W     = 32,
   parameter logic [31:0] LOCAL_BASE = 32'h0200_0048,
   parameter logic [31:0] LOCAL_END  = 32'h0200_004f,
   parameter logic [3:0]  AXI_ID     = 4'h1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wen,
   input  logic                    req_sign,
   input  logic [1:0]              req_size,
   input  logic [31:0]             req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    resp_valid,
   output logic [DATA_W-1:0]       resp_rdata,
   output logic                    resp_err,
   ysyx_25040111_lsu_axi_if.master bus,
   output logic [31:0]             pmc_ld,
   output logic [31:0]             pmc_st,
   output logic [31:0]             pmc_err,
   output logic [31:0]             pmc_wait
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   typedef enum logic [2:0] {
      IDLE, RADDR, RDATA, WRITE, WRESP, DONE
   } state_t;

   state_t state, state_nx;

   logic              wen_q, sign_q, loc_q, err_q;
   logic [1:0]        size_q;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              aw_done, w_done;

   logic [2:0] amask;
   logic       misal, bad_size, in_loc, pre_err;

   always_comb begin
      unique case (req_size)
         2'd0:    amask = 3'd0;
         2'd1:    amask = 3'd1;
         2'd2:    amask = 3'd3;
         default: amask = 3'd7;
      endcase
   end

   assign misal    = |(req_addr[2:0] & amask);
   assign bad_size = (req_size == 2'd3) && (DATA_W == 32);
   assign in_loc   = (req_addr >= LOCAL_BASE) && (req_addr <= LOCAL_END);
   // the local port has no write channel, so stores there fail up front
   assign pre_err  = misal | bad_size | (req_wen & in_loc);

   logic              accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic [1:0]        rresp_sel;
   logic [DATA_W-1:0] rdata_sel;

   assign accept = req_valid & req_ready;
   assign ar_hs  = loc_q ? (bus.loc_arvalid & bus.loc_arready)
                         : (bus.io_master_arvalid & bus.io_master_arready);
   assign r_hs   = loc_q ? (bus.loc_rvalid & bus.loc_rready)
                         : (bus.io_master_rvalid & bus.io_master_rready);
   assign aw_hs  = bus.io_master_awvalid & bus.io_master_awready;
   assign w_hs   = bus.io_master_wvalid & bus.io_master_wready;
   assign b_hs   = bus.io_master_bvalid & bus.io_master_bready;

   assign rresp_sel = loc_q ? bus.loc_rresp : bus.io_master_rresp;
   assign rdata_sel = loc_q ? bus.loc_rdata : bus.io_master_rdata;

   logic [OFF_W-1:0]  off;
   logic [OFF_W+2:0]  bsh;
   logic [7:0]        bmask;
   logic [DATA_W-1:0] rsh, lmask, ld_ext;
   logic              msb;

   assign off = addr_q[OFF_W-1:0];
   assign bsh = {off, 3'b000};
   assign rsh = rdata_sel >> bsh;

   always_comb begin
      bmask = 8'hff;
      lmask = '1;
      msb   = rsh[DATA_W-1];
      unique case (size_q)
         2'd0: begin
            bmask = 8'h01;
            lmask = DATA_W'(8'hff);
            msb   = rsh[7];
         end
         2'd1: begin
            bmask = 8'h03;
            lmask = DATA_W'(16'hffff);
            msb   = rsh[15];
         end
         2'd2: begin
            bmask = 8'h0f;
            lmask = DATA_W'(32'hffff_ffff);
            msb   = rsh[31];
         end
         default: ;
      endcase
      ld_ext = (rsh & lmask) | ((sign_q & msb) ? ~lmask : '0);
   end

   assign bus.io_master_awaddr  = addr_q;
   assign bus.io_master_awid    = AXI_ID;
   assign bus.io_master_awlen   = 8'd0;
   assign bus.io_master_awsize  = {1'b0, size_q};
   assign bus.io_master_awburst = 2'b01;
   assign bus.io_master_wdata   = wdata_q << bsh;
   assign bus.io_master_wstrb   = STRB_W'(bmask) << off;
   assign bus.io_master_araddr  = addr_q;
   assign bus.io_master_arid    = AXI_ID;
   assign bus.io_master_arlen   = 8'd0;
   assign bus.io_master_arsize  = {1'b0, size_q};
   assign bus.io_master_arburst = 2'b01;
   assign bus.loc_araddr        = addr_q;

   always_comb begin
      state_nx              = state;
      req_ready             = 1'b0;
      resp_valid            = 1'b0;
      resp_err              = 1'b0;
      resp_rdata            = '0;
      bus.io_master_arvalid = 1'b0;
      bus.io_master_rready  = 1'b0;
      bus.io_master_awvalid = 1'b0;
      bus.io_master_wvalid  = 1'b0;
      bus.io_master_wlast   = 1'b0;
      bus.io_master_bready  = 1'b0;
      bus.loc_arvalid       = 1'b0;
      bus.loc_rready        = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (pre_err)      state_nx = DONE;
               else if (req_wen) state_nx = WRITE;
               else              state_nx = RADDR;
            end
         end
         RADDR: begin
            bus.io_master_arvalid = ~loc_q;
            bus.loc_arvalid       = loc_q;
            if (ar_hs) state_nx = RDATA;
         end
         RDATA: begin
            bus.io_master_rready = ~loc_q;
            bus.loc_rready       = loc_q;
            if (r_hs) state_nx = DONE;
         end
         WRITE: begin
            bus.io_master_awvalid = ~aw_done;
            bus.io_master_wvalid  = ~w_done;
            bus.io_master_wlast   = ~w_done;
            if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = WRESP;
         end
         WRESP: begin
            bus.io_master_bready = 1'b1;
            if (b_hs) state_nx = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = rdata_q;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wen_q   <= 1'b0;
         sign_q  <= 1'b0;
         loc_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            wen_q   <= req_wen;
            sign_q  <= req_sign;
            loc_q   <= in_loc;
            err_q   <= pre_err;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (state == RDATA && r_hs) begin
            err_q   <= |rresp_sel;
            rdata_q <= (|rresp_sel) ? '0 : ld_ext;
         end
         if (state == WRESP && b_hs) err_q <= |bus.io_master_bresp;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{bus.io_master_rid, bus.io_master_bid,
                        bus.io_master_rlast};

`ifdef LSU_PMC_EN
   logic [31:0] ld_c, st_c, er_c, wt_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_c <= '0;
         st_c <= '0;
         er_c <= '0;
         wt_c <= '0;
      end else begin
         if (state == DONE) begin
            if (err_q)      er_c <= er_c + 32'd1;
            else if (wen_q) st_c <= st_c + 32'd1;
            else            ld_c <= ld_c + 32'd1;
         end
         if (state != IDLE && state != DONE) wt_c <= wt_c + 32'd1;
      end
   end

   assign pmc_ld   = ld_c;
   assign pmc_st   = st_c;
   assign pmc_err  = er_c;
   assign pmc_wait = wt_c;
`else
   assign pmc_ld   = '0;
   assign pmc_st   = '0;
   assign pmc_err  = '0;
   assign pmc_wait = '0;
`endif

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi.sv
// Bench for ysyx_25040111_lsu_axi: directed table, random traffic against a
// transaction-level model, and a mid-transaction reset sequence.
module tb_ysyx_25040111_lsu_axi;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen, req_sign;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] pmc_ld, pmc_st, pmc_err, pmc_wait;

   ysyx_25040111_lsu_axi_if #(.DATA_W(32)) bus ();

   ysyx_25040111_lsu_axi #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_sign   (req_sign),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .bus        (bus),
      .pmc_ld     (pmc_ld),
      .pmc_st     (pmc_st),
      .pmc_err    (pmc_err),
      .pmc_wait   (pmc_wait)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        wen, sign;
      bit [1:0]  size;
      bit [31:0] addr, wdata, srdata;
      bit [1:0]  sresp;
      int        ar_w, r_w, aw_w, w_w, b_w;
   } txn_t;

   typedef struct {
      bit        err;
      bit [31:0] rdata;
      int        lat;
      bit [31:0] wdata;
      bit [3:0]  wstrb;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   typedef struct {
      bit        acc, done, err, ar, loc, aw, w;
      bit        busy_rdy, wlast_bad, fix_bad, pulse_ok;
      bit [31:0] rdata, araddr, awaddr, wdata;
      bit [2:0]  arsize, awsize;
      bit [3:0]  wstrb;
      int        lat, aw_cyc, w_cyc;
   } obs_t;

   int total = 0;
   int passed = 0;

   task automatic chk(string nm, longint unsigned act, longint unsigned exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic bit is_loc(bit [31:0] a);
      return a >= 32'h0200_0048 && a <= 32'h0200_004f;
   endfunction

   function automatic bit pre_err(txn_t t);
      return (t.addr % (32'd1 << t.size)) != 0 || t.size == 2'd3 ||
             (t.wen && is_loc(t.addr));
   endfunction

   function automatic exp_t model(txn_t t);
      exp_t        e;
      int          off, nb;
      logic [63:0] v, m;
      off     = int'(t.addr % 4);
      e.wdata = t.wdata << (8 * off);
      e.wstrb = 4'(((1 << (1 << t.size)) - 1) << off);
      e.rdata = 0;
      if (pre_err(t)) begin
         e.err = 1;
         e.lat = 1;
         return e;
      end
      e.err = t.sresp != 0;
      if (t.wen) begin
         e.lat = 3 + (t.aw_w > t.w_w ? t.aw_w : t.w_w) + t.b_w;
      end else begin
         e.lat = 3 + t.ar_w + t.r_w;
         nb = 8 << t.size;
         m  = (64'd1 << nb) - 1;
         v  = (64'(t.srdata) >> (8 * off)) & m;
         if (t.sign && v[nb-1]) v = v | ~m;
         e.rdata = e.err ? 32'd0 : v[31:0];
      end
      return e;
   endfunction

   task automatic slave_idle();
      bus.io_master_awready = 0;
      bus.io_master_wready  = 0;
      bus.io_master_bvalid  = 0;
      bus.io_master_bresp   = 0;
      bus.io_master_bid     = 0;
      bus.io_master_arready = 0;
      bus.io_master_rvalid  = 0;
      bus.io_master_rresp   = 0;
      bus.io_master_rdata   = 0;
      bus.io_master_rlast   = 0;
      bus.io_master_rid     = 0;
      bus.loc_arready       = 0;
      bus.loc_rvalid        = 0;
      bus.loc_rdata         = 0;
      bus.loc_rresp         = 0;
   endtask

   task automatic do_reset();
      slave_idle();
      req_valid = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge.
   task automatic run(input txn_t t, output obs_t o);
      int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
      bit ar_ok = 0, r_ok = 0, aw_ok = 0, w_ok = 0, b_ok = 0;
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rv;
      o = '{default: 0};
      req_valid = 1;
      req_wen   = t.wen;
      req_sign  = t.sign;
      req_size  = t.size;
      req_addr  = t.addr;
      req_wdata = t.wdata;
      o.acc = req_ready;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      req_wen   = 1'($urandom);
      req_sign  = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      for (int c = 1; c <= 60; c++) begin
         if (resp_valid) begin
            o.done  = 1;
            o.lat   = c;
            o.err   = resp_err;
            o.rdata = resp_rdata;
            break;
         end
         if (req_ready) o.busy_rdy = 1;
         if (bus.io_master_arvalid) begin
            o.ar     = 1;
            o.araddr = bus.io_master_araddr;
            o.arsize = bus.io_master_arsize;
         end
         if (bus.loc_arvalid) begin
            o.loc    = 1;
            o.araddr = bus.loc_araddr;
         end
         if (bus.io_master_awvalid) begin
            o.aw = 1;
            o.aw_cyc++;
            o.awaddr = bus.io_master_awaddr;
            o.awsize = bus.io_master_awsize;
            if (bus.io_master_awlen != 0 || bus.io_master_awburst != 2'b01)
               o.fix_bad = 1;
         end
         if (bus.io_master_wvalid) begin
            o.w = 1;
            o.w_cyc++;
            o.wdata = bus.io_master_wdata;
            o.wstrb = bus.io_master_wstrb;
         end
         if (bus.io_master_wvalid != bus.io_master_wlast) o.wlast_bad = 1;

         bus.io_master_arready = bus.io_master_arvalid && ar_c >= t.ar_w;
         bus.loc_arready       = bus.loc_arvalid && ar_c >= t.ar_w;
         if (bus.io_master_arvalid || bus.loc_arvalid) ar_c++;
         rv = ar_ok && !r_ok && r_c >= t.r_w;
         bus.io_master_rvalid = rv && !o.loc;
         bus.loc_rvalid       = rv && o.loc;
         bus.io_master_rdata  = t.srdata;
         bus.loc_rdata        = t.srdata;
         bus.io_master_rresp  = t.sresp;
         bus.loc_rresp        = t.sresp;
         bus.io_master_rlast  = 1;
         bus.io_master_rid    = 4'h1;
         if (ar_ok && !r_ok) r_c++;
         bus.io_master_awready = bus.io_master_awvalid && aw_c >= t.aw_w;
         bus.io_master_wready  = bus.io_master_wvalid && w_c >= t.w_w;
         if (bus.io_master_awvalid) aw_c++;
         if (bus.io_master_wvalid) w_c++;
         bus.io_master_bvalid = aw_ok && w_ok && !b_ok && b_c >= t.b_w;
         bus.io_master_bresp  = t.sresp;
         bus.io_master_bid    = 4'h1;
         if (aw_ok && w_ok && !b_ok) b_c++;

         ar_hs = (bus.io_master_arvalid && bus.io_master_arready) ||
                 (bus.loc_arvalid && bus.loc_arready);
         r_hs  = (bus.io_master_rvalid && bus.io_master_rready) ||
                 (bus.loc_rvalid && bus.loc_rready);
         aw_hs = bus.io_master_awvalid && bus.io_master_awready;
         w_hs  = bus.io_master_wvalid && bus.io_master_wready;
         b_hs  = bus.io_master_bvalid && bus.io_master_bready;
         @(posedge clk);
         ar_ok |= ar_hs;
         r_ok  |= r_hs;
         aw_ok |= aw_hs;
         w_ok  |= w_hs;
         b_ok  |= b_hs;
         @(negedge clk);
      end
      slave_idle();
      if (o.done) begin
         @(posedge clk);
         @(negedge clk);
         o.pulse_ok = !resp_valid && req_ready;
      end
   endtask

   task automatic check(string nm, txn_t t, exp_t e);
      obs_t o;
      bit   pe, lc;
      run(t, o);
      pe = pre_err(t);
      lc = is_loc(t.addr);
      chk({nm, " accept"}, o.acc, 1);
      chk({nm, " done"}, o.done, 1);
      if (!o.done) begin
         do_reset();
         return;
      end
      chk({nm, " lat"}, o.lat, e.lat);
      chk({nm, " err"}, o.err, e.err);
      chk({nm, " rdata"}, o.rdata, e.rdata);
      chk({nm, " pulse"}, o.pulse_ok, 1);
      chk({nm, " busy_ready"}, o.busy_rdy, 0);
      chk({nm, " ar"}, o.ar, !pe && !t.wen && !lc);
      chk({nm, " loc_ar"}, o.loc, !pe && !t.wen && lc);
      chk({nm, " aw"}, o.aw, !pe && t.wen);
      chk({nm, " w"}, o.w, !pe && t.wen);
      if (o.ar || o.loc) chk({nm, " araddr"}, o.araddr, t.addr);
      if (o.ar) chk({nm, " arsize"}, o.arsize, t.size);
      if (o.aw) begin
         chk({nm, " awaddr"}, o.awaddr, t.addr);
         chk({nm, " awsize"}, o.awsize, t.size);
         chk({nm, " awlen_burst"}, o.fix_bad, 0);
         chk({nm, " wdata"}, o.wdata, e.wdata);
         chk({nm, " wstrb"}, o.wstrb, e.wstrb);
         chk({nm, " aw_cycles"}, o.aw_cyc, t.aw_w + 1);
         chk({nm, " w_cycles"}, o.w_cyc, t.w_w + 1);
         chk({nm, " wlast"}, o.wlast_bad, 0);
      end
   endtask

   function automatic txn_t mkt(bit wen, bit sign, bit [1:0] size,
                                bit [31:0] addr, bit [31:0] wdata,
                                bit [31:0] srdata, bit [1:0] sresp,
                                int arw, int rw, int aww, int ww, int bw);
      txn_t t;
      t.wen = wen; t.sign = sign; t.size = size; t.addr = addr;
      t.wdata = wdata; t.srdata = srdata; t.sresp = sresp;
      t.ar_w = arw; t.r_w = rw; t.aw_w = aww; t.w_w = ww; t.b_w = bw;
      return t;
   endfunction

   function automatic exp_t mke(bit err, bit [31:0] rdata, int lat,
                                bit [31:0] wdata, bit [3:0] wstrb);
      exp_t e;
      e.err = err; e.rdata = rdata; e.lat = lat;
      e.wdata = wdata; e.wstrb = wstrb;
      return e;
   endfunction

   vec_t vecs[13];

   initial begin
      txn_t t;
      exp_t e;
      vecs[0]  = '{mkt(0,0,2,32'h8000_0004,0,32'hDEAD_BEEF,0,0,0,0,0,0),
                   mke(0,32'hDEAD_BEEF,3,0,0)};
      vecs[1]  = '{mkt(0,1,0,32'h8000_0003,0,32'h8F00_0000,0,0,0,0,0,0),
                   mke(0,32'hFFFF_FF8F,3,0,0)};
      vecs[2]  = '{mkt(0,0,0,32'h8000_0003,0,32'h8F00_0000,0,0,0,0,0,0),
                   mke(0,32'h0000_008F,3,0,0)};
      vecs[3]  = '{mkt(1,0,1,32'h8000_0002,32'h1234,0,0,0,0,3,0,0),
                   mke(0,0,6,32'h1234_0000,4'b1100)};
      vecs[4]  = '{mkt(0,0,2,32'h0200_0048,0,32'h0000_0042,0,0,0,0,0,0),
                   mke(0,32'h42,3,0,0)};
      vecs[5]  = '{mkt(0,0,1,32'h8000_0001,0,32'h1111_1111,0,0,0,0,0,0),
                   mke(1,0,1,0,0)};
      vecs[6]  = '{mkt(1,0,2,32'h8000_0000,32'hCAFE_F00D,0,2'b10,0,0,0,0,0),
                   mke(1,0,3,32'hCAFE_F00D,4'hF)};
      vecs[7]  = '{mkt(0,0,3,32'h8000_0008,0,32'h5,0,0,0,0,0,0),
                   mke(1,0,1,0,0)};
      vecs[8]  = '{mkt(1,0,2,32'h0200_004c,32'h77,0,0,0,0,0,0,0),
                   mke(1,0,1,0,0)};
      vecs[9]  = '{mkt(0,0,2,32'h8000_0020,0,32'h1234_5678,2'b11,0,0,0,0,0),
                   mke(1,0,3,0,0)};
      vecs[10] = '{mkt(0,1,1,32'h8000_0002,0,32'h8001_5555,0,2,1,0,0,0),
                   mke(0,32'hFFFF_8001,6,0,0)};
      vecs[11] = '{mkt(1,0,0,32'h8000_0001,32'hAB,0,0,0,0,0,2,1),
                   mke(0,0,6,32'h0000_AB00,4'b0010)};
      vecs[12] = '{mkt(0,0,1,32'h0200_004a,0,32'h9ABC_0000,0,0,0,0,0,0),
                   mke(0,32'h0000_9ABC,3,0,0)};

      req_valid = 0; req_wen = 0; req_sign = 0; req_size = 0;
      req_addr = 0; req_wdata = 0;
      rst = 1;
      slave_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset idle", {req_ready, resp_valid, resp_err}, 3'b100);
      chk("reset rdata", resp_rdata, 0);
      chk("reset valids", {bus.io_master_arvalid, bus.io_master_rready,
                           bus.io_master_awvalid, bus.io_master_wvalid,
                           bus.io_master_bready, bus.loc_arvalid,
                           bus.loc_rready}, 0);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < 13; i++)
         check($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);

      // reset while waiting in RDATA
      req_valid = 1; req_wen = 0; req_sign = 0; req_size = 2;
      req_addr = 32'h8000_0010; req_wdata = 0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      chk("rst arvalid", bus.io_master_arvalid, 1);
      bus.io_master_arready = 1;
      @(posedge clk);
      @(negedge clk);
      bus.io_master_arready = 0;
      chk("rst rready", bus.io_master_rready, 1);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      chk("rst after", {bus.io_master_arvalid, bus.io_master_rready,
                        req_ready, resp_valid}, 4'b0010);
      check("post_rst", vecs[0].t, vecs[0].e);

      for (int i = 0; i < 150; i++) begin
         t.wen  = 1'($urandom);
         t.sign = 1'($urandom);
         t.size = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            t.addr = 32'h0200_0048 + $urandom_range(0, 7);
         else
            t.addr = 32'h8000_0000 + ($urandom & 32'hfff);
         if ($urandom_range(0, 3) != 0)
            t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
         t.wdata  = $urandom;
         t.srdata = $urandom;
         t.sresp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         t.ar_w = $urandom_range(0, 3);
         t.r_w  = $urandom_range(0, 3);
         t.aw_w = $urandom_range(0, 3);
         t.w_w  = $urandom_range(0, 3);
         t.b_w  = $urandom_range(0, 3);
         e = model(t);
         check($sformatf("rnd%0d", i), t, e);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
